// File: rtl/l1i_lru_controller_pkg.sv
// l1i_lru_controller_pkg: shared types and helpers for the L1I pseudo-LRU sequencer
package l1i_lru_controller_pkg;
    localparam int NUM_L1I_WAYS  = 4;
    localparam int L1I_NUM_SETS  = 64;
    localparam int L1I_SET_WIDTH = $clog2(L1I_NUM_SETS);

    typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE, COMMIT} l1i_lru_state_t;

    typedef struct packed {
        logic [L1I_SET_WIDTH-1:0] set;
        logic [NUM_L1I_WAYS-1:0]  way_oh;
    } hit_update_t;

    function automatic logic is_onehot(input logic [NUM_L1I_WAYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
endpackage

// File: rtl/l1i_lru_controller_hit_fifo.sv
// l1i_hit_fifo: synchronous FIFO of pending hit-recency updates
module l1i_hit_fifo
    import l1i_lru_controller_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  hit_update_t push_data,
    input  logic        pop,
    output hit_update_t pop_data,
    output logic        full,
    output logic        empty,
    output logic        almost_full
);
    localparam int AW = $clog2(DEPTH);

    hit_update_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    // a pop frees the slot a push into a full queue needs
    assign do_pop      = pop && !empty;
    assign do_push     = push && (!full || do_pop);
    assign full        = count == (AW+1)'(DEPTH);
    assign empty       = count == '0;
    assign almost_full = count >= (AW+1)'(DEPTH - 1);
    assign pop_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/l1i_lru_controller.sv
// l1i_lru_controller: serialises hit-recency updates and fill victim lookups onto the
// single-ported pseudo-LRU tracker and presents the chosen victim to the L1I arrays.
module l1i_lru_controller
    import l1i_lru_controller_pkg::*;
#(
    parameter int NUM_SETS        = L1I_NUM_SETS,
    parameter int SET_WIDTH       = $clog2(NUM_SETS),
    parameter int TAG_WIDTH       = 20,
    parameter int HIT_QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hit_valid,
    input  logic [SET_WIDTH-1:0]    hit_set,
    input  logic [NUM_L1I_WAYS-1:0] hit_way_oh,
    input  logic                    fill_req_valid,
    output logic                    fill_req_ready,
    input  logic [SET_WIDTH-1:0]    fill_req_set,
    input  logic [TAG_WIDTH-1:0]    fill_req_tag,
    output logic                    fill_commit_valid,
    input  logic                    fill_commit_ready,
    output logic [SET_WIDTH-1:0]    fill_commit_set,
    output logic [NUM_L1I_WAYS-1:0] fill_commit_way_oh,
    output logic [TAG_WIDTH-1:0]    fill_commit_tag,
    output logic [7:0]              hit_drop_count,
    output logic                    lru_fill_en,
    output logic [SET_WIDTH-1:0]    lru_fill_set,
    output logic                    lru_access_en,
    output logic                    lru_update_en,
    output logic [SET_WIDTH-1:0]    lru_access_set,
    output logic [NUM_L1I_WAYS-1:0] lru_access_way_oh,
    input  logic [NUM_L1I_WAYS-1:0] lru_fill_way_oh
);
    l1i_lru_state_t state;
    hit_update_t    push_data, head, upd_q;
    logic           upd_valid, q_full, q_empty, accept, issue, drop;

    assign push_data = {hit_set, hit_way_oh};

    l1i_hit_fifo #(.DEPTH(HIT_QUEUE_DEPTH)) u_hit_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (hit_valid),
        .push_data   (push_data),
        .pop         (issue),
        .pop_data    (head),
        .full        (q_full),
        .empty       (q_empty),
        .almost_full ()
    );

    // fills only start when the tracker write port is free this cycle
    assign accept = !reset && state == IDLE && fill_req_valid && !upd_valid;
    assign issue  = !reset && !q_empty && !accept && state != LOOKUP && state != CAPTURE &&
                    !(upd_valid && head.set == upd_q.set);
    assign drop   = hit_valid && q_full && !issue;

    assign fill_req_ready    = accept;
    assign lru_access_en     = issue;
    assign lru_access_set    = issue ? head.set : '0;
    assign lru_update_en     = upd_valid;
    assign lru_access_way_oh = upd_valid ? upd_q.way_oh : '0;
    assign lru_fill_set      = lru_fill_en ? fill_commit_set : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            upd_valid          <= 1'b0;
            upd_q              <= '0;
            lru_fill_en        <= 1'b0;
            fill_commit_valid  <= 1'b0;
            fill_commit_set    <= '0;
            fill_commit_tag    <= '0;
            fill_commit_way_oh <= '0;
            hit_drop_count     <= '0;
        end else begin
            upd_valid <= issue;
            if (issue) upd_q <= head;
            if (drop && hit_drop_count != 8'hff) hit_drop_count <= hit_drop_count + 1'b1;
            case (state)
                IDLE: if (accept) begin
                    state           <= LOOKUP;
                    lru_fill_en     <= 1'b1;
                    fill_commit_set <= fill_req_set;
                    fill_commit_tag <= fill_req_tag;
                end
                LOOKUP: begin
                    state       <= CAPTURE;
                    lru_fill_en <= 1'b0;
                end
                CAPTURE: begin
                    state              <= COMMIT;
                    fill_commit_valid  <= 1'b1;
                    fill_commit_way_oh <= is_onehot(lru_fill_way_oh) ? lru_fill_way_oh
                                                                      : NUM_L1I_WAYS'(1);
                end
                COMMIT: if (fill_commit_ready) begin
                    state             <= IDLE;
                    fill_commit_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_l1i_lru_controller.sv
// tb_l1i_lru_controller: scoreboard bench for the L1I LRU sequencer
module tb_l1i_lru_controller;
    logic        clk = 1'b0, reset = 1'b1;
    logic        hit_valid = 1'b0;
    logic [5:0]  hit_set = '0;
    logic [3:0]  hit_way_oh = '0;
    logic        fill_req_valid = 1'b0, fill_req_ready;
    logic [5:0]  fill_req_set = '0;
    logic [19:0] fill_req_tag = '0;
    logic        fill_commit_valid, fill_commit_ready = 1'b1;
    logic [5:0]  fill_commit_set;
    logic [3:0]  fill_commit_way_oh;
    logic [19:0] fill_commit_tag;
    logic [7:0]  hit_drop_count;
    logic        lru_fill_en, lru_access_en, lru_update_en;
    logic [5:0]  lru_fill_set, lru_access_set;
    logic [3:0]  lru_access_way_oh;
    logic [3:0]  lru_fill_way_oh = '0;

    l1i_lru_controller dut (
        .clk(clk), .reset(reset),
        .hit_valid(hit_valid), .hit_set(hit_set), .hit_way_oh(hit_way_oh),
        .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
        .fill_req_set(fill_req_set), .fill_req_tag(fill_req_tag),
        .fill_commit_valid(fill_commit_valid), .fill_commit_ready(fill_commit_ready),
        .fill_commit_set(fill_commit_set), .fill_commit_way_oh(fill_commit_way_oh),
        .fill_commit_tag(fill_commit_tag), .hit_drop_count(hit_drop_count),
        .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set),
        .lru_access_en(lru_access_en), .lru_update_en(lru_update_en),
        .lru_access_set(lru_access_set), .lru_access_way_oh(lru_access_way_oh),
        .lru_fill_way_oh(lru_fill_way_oh)
    );

    always #5 clk = ~clk;

    typedef struct { logic [5:0] set; logic [3:0] way; int cyc; int lat; } hit_exp_t;
    typedef struct { logic [5:0] set; logic [3:0] way; logic [19:0] tag; } fill_exp_t;
    hit_exp_t  hq[$], pq[$];
    fill_exp_t fq[$];
    int  checks = 0, failures = 0, cyc = 0, acc_cyc = -100;
    int  hit_lat_exp = 0;
    bit  hit_drop_exp = 1'b0, sb_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] victim(input logic [3:0] w);
        return ($countones(w) == 1) ? w : 4'b0001;
    endfunction

    // monitor: scoreboards plus per-cycle port-sharing rules
    initial begin
        hit_exp_t e;
        logic prev_cv = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hq.delete(); pq.delete(); fq.delete();
                acc_cyc = -100;
                prev_cv = 1'b0;
            end else begin
                if (fill_req_valid && fill_req_ready) begin
                    acc_cyc = cyc;
                    fq.push_back('{fill_req_set, victim(lru_fill_way_oh), fill_req_tag});
                end
                check("fill_access_excl", 32'(lru_fill_en & lru_access_en), 0);
                check("fill_en_slot", 32'(lru_fill_en), 32'(cyc == acc_cyc + 1));
                if (cyc >= acc_cyc && cyc <= acc_cyc + 2) check("access_blocked", 32'(lru_access_en), 0);
                if (cyc == acc_cyc + 2) check("update_blocked", 32'(lru_update_en), 0);
                if (sb_en && lru_update_en) begin
                    if (pq.size() == 0) check("update_spurious", 1, 0);
                    else begin
                        e = pq.pop_front();
                        check("update_way", 32'(lru_access_way_oh), 32'(e.way));
                        check("update_lat", 32'(cyc - e.cyc), 1);
                    end
                end
                if (sb_en && lru_access_en) begin
                    if (hq.size() == 0) check("access_spurious", 1, 0);
                    else begin
                        e = hq.pop_front();
                        check("access_set", 32'(lru_access_set), 32'(e.set));
                        if (e.lat != 0) check("access_lat", 32'(cyc - e.cyc), 32'(e.lat));
                        e.cyc = cyc;
                        pq.push_back(e);
                    end
                end
                if (sb_en && hit_valid && !hit_drop_exp) hq.push_back('{hit_set, hit_way_oh, cyc, hit_lat_exp});
                if (fill_commit_valid) begin
                    if (fq.size() == 0) check("commit_spurious", 1, 0);
                    else begin
                        if (!prev_cv) check("commit_lat", 32'(cyc - acc_cyc), 3);
                        check("commit_set", 32'(fill_commit_set), 32'(fq[0].set));
                        check("commit_way", 32'(fill_commit_way_oh), 32'(fq[0].way));
                        check("commit_tag", 32'(fill_commit_tag), 32'(fq[0].tag));
                        if (fill_commit_ready) void'(fq.pop_front());
                    end
                end
                prev_cv = fill_commit_valid;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [5:0] s, input logic [3:0] w, input int lat, input bit drop);
        hit_valid = 1'b1; hit_set = s; hit_way_oh = w;
        hit_lat_exp = lat; hit_drop_exp = drop;
        step();
        hit_valid = 1'b0; hit_drop_exp = 1'b0;
    endtask

    task automatic fill_go(input logic [5:0] s, input logic [19:0] t, input logic [3:0] w);
        bit ok = 1'b0;
        fill_req_valid = 1'b1; fill_req_set = s; fill_req_tag = t; lru_fill_way_oh = w;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = fill_req_ready;
            step();
        end
        fill_req_valid = 1'b0;
        check("fill_accept", 32'(ok), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((hq.size() != 0 || pq.size() != 0 || fq.size() != 0 || fill_commit_valid) && n < 100) begin
            step();
            n++;
        end
        check("drain", 32'(n < 100), 1);
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(fill_req_ready), 0);
        check({tag, "_commit_valid"}, 32'(fill_commit_valid), 0);
        check({tag, "_commit_way"}, 32'(fill_commit_way_oh), 0);
        check({tag, "_fill_en"}, 32'(lru_fill_en), 0);
        check({tag, "_access_en"}, 32'(lru_access_en), 0);
        check({tag, "_update_en"}, 32'(lru_update_en), 0);
        check({tag, "_drops"}, 32'(hit_drop_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        reset = 1'b0;
        check_idle_outputs("reset");
        // four hits to distinct sets: access one cycle after push, update one after access
        for (int i = 1; i <= 4; i++) hit(6'(i), 4'b0001 << (i % 4), 1, 1'b0);
        drain();
        fill_go(6'd5, 20'hABCDE, 4'b0100);
        drain();
        // same set back to back: second access waits one extra cycle
        hit(6'd7, 4'b0001, 1, 1'b0);
        hit(6'd7, 4'b0010, 2, 1'b0);
        drain();
        // fill accepted alongside a hit stream; non-one-hot victim falls back to way 0
        fill_req_valid = 1'b1; fill_req_set = 6'd9; fill_req_tag = 20'h12345; lru_fill_way_oh = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            hit(6'(8 + i), 4'b0001 << (i % 4), 0, 1'b0);
            fill_req_valid = 1'b0;
        end
        drain();
        // two fills bracket a same-set hit burst; the last two hits find the queue full
        fill_req_valid = 1'b1; fill_req_set = 6'h11; fill_req_tag = 20'h0F0F0; lru_fill_way_oh = 4'b1000;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) fill_req_tag = 20'h0F0F1;
            if (i == 6) fill_req_valid = 1'b0;
            hit(6'd7, 4'b0001 << (i % 4), 0, i >= 5);
        end
        fill_req_valid = 1'b0;
        drain();
        check("drop_count", 32'(hit_drop_count), 2);
        // commit held off by the arrays
        fill_commit_ready = 1'b0;
        fill_go(6'h2A, 20'h55555, 4'b1000);
        for (int i = 0; i < 10 && !fill_commit_valid; i++) step();
        repeat (5) step();
        check("commit_hold", 32'(fill_commit_valid), 1);
        fill_commit_ready = 1'b1;
        drain();
        // reset while the lookup is in flight
        fill_go(6'd3, 20'h33333, 4'b0001);
        check("in_lookup", 32'(lru_fill_en), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_outputs("midreset");
        fill_go(6'd4, 20'h44444, 4'b0010);
        drain();
        // long same-set stream keeps the queue full: counter saturates
        sb_en = 1'b0;
        hit_valid = 1'b1; hit_set = 6'd7; hit_way_oh = 4'b0001;
        repeat (700) step();
        hit_valid = 1'b0;
        step();
        check("drop_saturate", 32'(hit_drop_count), 255);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb_en = 1'b1;
        check("drop_cleared", 32'(hit_drop_count), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
